// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the PC register and decode.
// It issues one read per cycle to a synchronous instruction memory while it
// has free space. Each returned {pc, instruction} pair is written into a small
// circular FIFO, and decode drains the FIFO over a valid/ready handshake.
// A branch redirect (flush) discards buffered entries and the in-flight fetch.

module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AW-1:0]            pc_in,
    output logic                     pc_en,
    input  logic                     flush,
    output logic [AW-1:0]            imem_addr,
    output logic                     imem_rd_en,
    input  logic [DW-1:0]            imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_instr,
    output logic [AW-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Extra bit so that count + inflight cannot wrap when the FIFO is full.
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [CW-1:0] count_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          inflight;
    logic [AW-1:0] inflight_pc;

    logic [AW-1:0] mem_pc    [DEPTH];
    logic [DW-1:0] mem_instr [DEPTH];

    logic [CW:0]   reserved;
    logic          has_credit;
    logic          push;
    logic          pop;

    // Credit check and handshake qualifiers; flush overrides everything.
    always_comb begin
        reserved   = {1'b0, count_q} + (CW + 1)'(inflight);
        has_credit = (reserved < DEPTH_C);
        push       = inflight & ~flush;
        pop        = (count_q != '0) & out_ready & ~flush;
    end

    // Issue side: request the current PC while space is reserved.
    // pc_en also covers the redirect load of the PC register.
    always_comb begin
        imem_addr  = pc_in;
        imem_rd_en = rst & ~flush & has_credit;
        pc_en      = rst & (imem_rd_en | flush);
    end

    // Track the single outstanding read and the PC it was issued for.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight    <= imem_rd_en;
            inflight_pc <= pc_in;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage. Flush only moves the pointers and leaves the contents in
    // place, so an empty queue keeps showing whatever slot 0 last held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (push) begin
            mem_pc[wr_ptr]    <= inflight_pc;
            mem_instr[wr_ptr] <= imem_rdata;
        end
    end

    // Decode-facing outputs. They are forced to zero while reset is held,
    // because storage is only cleared at the reset edge.
    always_comb begin
        out_valid = rst & (count_q != '0);
        out_instr = rst ? mem_instr[rd_ptr] : '0;
        out_pc    = rst ? mem_pc[rd_ptr] : '0;
        count     = rst ? count_q : '0;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4). The PC register and the
// instruction memory are modelled around the DUT. The memory returns
// addr ^ 32'h5A00_0013 one cycle after each read request.

module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        flush;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    logic [31:0] target;
    int          vectors;
    int          miscompares;
    int          nreq;
    logic [31:0] exp_pc;

    fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_en      (pc_en),
        .flush      (flush),
        .imem_addr  (imem_addr),
        .imem_rd_en (imem_rd_en),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    // PC register: redirect on flush, step by 4 when the DUT advances it.
    always @(posedge clk) begin
        if (!rst)        pc_in <= 32'h0;
        else if (flush)  pc_in <= target;
        else if (pc_en)  pc_in <= pc_in + 32'd4;
    end

    // Synchronous instruction memory with 1-cycle latency; garbage otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_rd_en ? instr_of(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        target      = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_rd_en", 32'(imem_rd_en), 32'h0);
        chk("rst_pc_en", 32'(pc_en), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);

        // Streaming with out_ready=1
        @(negedge clk); rst = 1'b1; #1;
        chk("s_rd_en0", 32'(imem_rd_en), 32'h1);
        chk("s_addr0", imem_addr, 32'h0);
        chk("s_pc_en0", 32'(pc_en), 32'h1);
        chk("s_valid0", 32'(out_valid), 32'h0);
        @(negedge clk); #1;
        chk("s_valid1", 32'(out_valid), 32'h0);
        chk("s_addr1", imem_addr, 32'h4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("s_valid", 32'(out_valid), 32'h1);
            chk("s_out_pc", out_pc, 32'(4 * k));
            chk("s_out_instr", out_instr, instr_of(32'(4 * k)));
            chk("s_count", 32'(count), 32'h1);
        end

        // Fill to full with out_ready=0
        @(negedge clk); rst = 1'b0; out_ready = 1'b0;
        @(negedge clk); rst = 1'b1;
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (imem_rd_en) begin
                chk("f_req_addr", imem_addr, 32'(nreq * 4));
                nreq++;
            end
            @(negedge clk);
        end
        #1;
        chk("f_nreq", 32'(nreq), 32'd4);
        chk("f_count", 32'(count), 32'd4);
        chk("f_rd_en", 32'(imem_rd_en), 32'h0);
        chk("f_pc_en", 32'(pc_en), 32'h0);
        chk("f_pc_in", pc_in, 32'h10);
        chk("f_head", out_pc, 32'h0);

        // Single pop from full
        @(negedge clk); out_ready = 1'b1; #1;
        chk("p_head", out_pc, 32'h0);
        chk("p_no_credit", 32'(imem_rd_en), 32'h0);
        @(negedge clk); out_ready = 1'b0; #1;
        chk("p_count3", 32'(count), 32'd3);
        chk("p_head4", out_pc, 32'h4);
        chk("p_rd_en", 32'(imem_rd_en), 32'h1);
        chk("p_addr", imem_addr, 32'h10);
        @(negedge clk); #1;
        chk("p_count3b", 32'(count), 32'd3);
        chk("p_rd_en_off", 32'(imem_rd_en), 32'h0);
        @(negedge clk); #1;
        chk("p_count4", 32'(count), 32'd4);

        // Flush with count=3 and a request in flight
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0; #1;
        chk("x_count3", 32'(count), 32'd3);
        chk("x_req", imem_addr, 32'h14);
        @(negedge clk); flush = 1'b1; target = 32'h100; #1;
        chk("x_rd_en_flush", 32'(imem_rd_en), 32'h0);
        chk("x_pc_en_flush", 32'(pc_en), 32'h1);
        @(negedge clk); flush = 1'b0; out_ready = 1'b1; #1;
        chk("x_count0", 32'(count), 32'h0);
        chk("x_valid0", 32'(out_valid), 32'h0);
        chk("x_rd_en", 32'(imem_rd_en), 32'h1);
        chk("x_addr", imem_addr, 32'h100);
        @(negedge clk); #1;
        chk("x_valid_still0", 32'(out_valid), 32'h0);
        chk("x_addr2", imem_addr, 32'h104);
        @(negedge clk); #1;
        chk("x_valid1", 32'(out_valid), 32'h1);
        chk("x_first_pc", out_pc, 32'h100);
        chk("x_first_instr", out_instr, instr_of(32'h100));
        exp_pc = 32'h104;

        // Steady count=2 with simultaneous push/pop across pointer wrap
        @(negedge clk); out_ready = 1'b0; #1;
        chk("w_head", out_pc, exp_pc);
        chk("w_count1", 32'(count), 32'd1);
        @(negedge clk); out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("w_out_pc", out_pc, exp_pc);
            chk("w_out_instr", out_instr, instr_of(exp_pc));
            chk("w_count2", 32'(count), 32'd2);
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end

        // Reset mid-operation (count=2, inflight=1)
        rst = 1'b0; out_ready = 1'b0; #1;
        chk("r_valid", 32'(out_valid), 32'h0);
        chk("r_instr", out_instr, 32'h0);
        chk("r_pc", out_pc, 32'h0);
        chk("r_rd_en", 32'(imem_rd_en), 32'h0);
        chk("r_pc_en", 32'(pc_en), 32'h0);
        chk("r_count", 32'(count), 32'h0);
        @(negedge clk); rst = 1'b1; #1;
        chk("r_count_rel", 32'(count), 32'h0);
        chk("r_valid_rel", 32'(out_valid), 32'h0);
        chk("r_rd_en_rel", 32'(imem_rd_en), 32'h1);
        chk("r_addr_rel", imem_addr, 32'h0);
        @(negedge clk); #1;
        chk("r_count_rel1", 32'(count), 32'h0);
        @(negedge clk); #1;
        chk("r_count_rel2", 32'(count), 32'h1);
        chk("r_first_pc", out_pc, 32'h0);
        chk("r_first_instr", out_instr, instr_of(32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
